// File: rtl/control_unit_pkg.sv
// Shared ISA definitions for the hardwired control unit: opcodes, ALU/FPU
// one-hot bit positions, FPU function codes, T-step state encodings and
// instruction classes produced by the decoder.
package control_unit_pkg;

  // Opcodes, ir[31:27]
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_HALT = 5'd26;
  localparam logic [4:0] FPU_OPCODE_DEF = 5'b11011;

  // alu_select bit positions {not,neg,div,mul,or,and,rol,ror,shl,shr,sub,add}
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SHR = 2;
  localparam int ALU_SHL = 3;
  localparam int ALU_ROR = 4;
  localparam int ALU_ROL = 5;
  localparam int ALU_AND = 6;
  localparam int ALU_OR  = 7;
  localparam int ALU_MUL = 8;
  localparam int ALU_DIV = 9;
  localparam int ALU_NEG = 10;
  localparam int ALU_NOT = 11;

  // FPU function codes, ir[3:0]; also the fpu_select bit position
  localparam logic [3:0] FPU_MVRF = 4'd0;
  localparam logic [3:0] FPU_MVFR = 4'd1;
  localparam logic [3:0] FPU_CRF  = 4'd2;
  localparam logic [3:0] FPU_CFR  = 4'd3;
  localparam logic [3:0] FPU_CURF = 4'd4;
  localparam logic [3:0] FPU_CUFR = 4'd5;
  localparam logic [3:0] FPU_FADD = 4'd6;
  localparam logic [3:0] FPU_FSUB = 4'd7;
  localparam logic [3:0] FPU_FMUL = 4'd8;
  localparam logic [3:0] FPU_FRC  = 4'd9;
  localparam logic [3:0] FPU_FGT  = 4'd10;
  localparam logic [3:0] FPU_FEQ  = 4'd11;
  localparam logic [3:0] FPU_NFUNC = 4'd12;

  // Sequencer T-steps
  localparam logic [2:0] ST_RESET_IDLE = 3'd0;
  localparam logic [2:0] ST_T0         = 3'd1;
  localparam logic [2:0] ST_T1         = 3'd2;
  localparam logic [2:0] ST_T2         = 3'd3;
  localparam logic [2:0] ST_T3         = 3'd4;
  localparam logic [2:0] ST_T4         = 3'd5;
  localparam logic [2:0] ST_T5         = 3'd6;
  localparam logic [2:0] ST_HALT       = 3'd7;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_ALU_U, CLS_MULDIV, CLS_MFHI, CLS_MFLO,
    CLS_LD, CLS_ST, CLS_BR, CLS_JR, CLS_JAL, CLS_FPU, CLS_HALT
  } instr_class_e;

  // FPU functions whose result lands in the integer register file
  function automatic logic fpu_writes_rf(input logic [3:0] func);
    return (func == FPU_MVFR) || (func == FPU_CFR) || (func == FPU_CUFR) ||
           (func == FPU_FGT)  || (func == FPU_FEQ);
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode decoder: maps ir[31:27] to an instruction class and
// the one-hot ALU operation used during that instruction's T3 step.
module control_decode
  import control_unit_pkg::*;
#(
  parameter logic [4:0] FPU_OPCODE = FPU_OPCODE_DEF
) (
  input  logic [4:0]   opcode_i,
  output instr_class_e cls_o,
  output logic [11:0]  alu_sel_o
);

  // Opcode to class and ALU op; anything unlisted decodes as a no-op
  always_comb begin
    cls_o     = CLS_NOP;
    alu_sel_o = '0;
    if (opcode_i == FPU_OPCODE) begin
      cls_o = CLS_FPU;
    end else begin
      case (opcode_i)
        OP_ADD:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_ADD] = 1'b1; end
        OP_SUB:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_SUB] = 1'b1; end
        OP_SHR:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_SHR] = 1'b1; end
        OP_SHL:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_SHL] = 1'b1; end
        OP_ROR:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_ROR] = 1'b1; end
        OP_ROL:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_ROL] = 1'b1; end
        OP_AND:  begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_AND] = 1'b1; end
        OP_OR:   begin cls_o = CLS_ALU_R;  alu_sel_o[ALU_OR]  = 1'b1; end
        OP_ADDI, OP_LDI:
                 begin cls_o = CLS_ALU_I;  alu_sel_o[ALU_ADD] = 1'b1; end
        OP_ANDI: begin cls_o = CLS_ALU_I;  alu_sel_o[ALU_AND] = 1'b1; end
        OP_ORI:  begin cls_o = CLS_ALU_I;  alu_sel_o[ALU_OR]  = 1'b1; end
        OP_NEG:  begin cls_o = CLS_ALU_U;  alu_sel_o[ALU_NEG] = 1'b1; end
        OP_NOT:  begin cls_o = CLS_ALU_U;  alu_sel_o[ALU_NOT] = 1'b1; end
        OP_MUL:  begin cls_o = CLS_MULDIV; alu_sel_o[ALU_MUL] = 1'b1; end
        OP_DIV:  begin cls_o = CLS_MULDIV; alu_sel_o[ALU_DIV] = 1'b1; end
        OP_LD:   begin cls_o = CLS_LD;     alu_sel_o[ALU_ADD] = 1'b1; end
        OP_ST:   begin cls_o = CLS_ST;     alu_sel_o[ALU_ADD] = 1'b1; end
        OP_BR:   begin cls_o = CLS_BR;     alu_sel_o[ALU_ADD] = 1'b1; end
        OP_JAL:  begin cls_o = CLS_JAL;    alu_sel_o[ALU_ADD] = 1'b1; end
        OP_JR:   cls_o = CLS_JR;
        OP_MFHI: cls_o = CLS_MFHI;
        OP_MFLO: cls_o = CLS_MFLO;
        OP_HALT: cls_o = CLS_HALT;
        default: cls_o = CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the cpu datapath. Steps T0..T5 fetch, decode
// and execute one instruction per pass; outputs are a pure decode of the
// current step and ir. HALT is sticky until clr.
module control_unit
  import control_unit_pkg::*;
#(
  parameter logic [4:0] FPU_OPCODE  = FPU_OPCODE_DEF,
  parameter bit          BRANCH_TAKE = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        branch_condition,
  output logic        ir_en,
  output logic        pc_increment,
  output logic        pc_in_alu,
  output logic        pc_in_rf_a,
  output logic        ma_in_pc,
  output logic        ma_in_alu,
  output logic        alu_a_in_rf,
  output logic        alu_a_in_pc,
  output logic        alu_b_in_rf,
  output logic        alu_b_in_constant,
  output logic        lo_en,
  output logic        hi_en,
  output logic        memory_en,
  output logic        rf_in_alu,
  output logic        rf_in_hi,
  output logic        rf_in_lo,
  output logic        rf_in_memory,
  output logic        rf_in_fpu,
  output logic [11:0] alu_select,
  output logic [11:0] fpu_select,
  output logic        fpu_mode,
  output logic        run
);

  logic [2:0]   state_q, state_d;
  instr_class_e cls;
  logic [11:0]  dec_alu_sel;
  logic [3:0]   fpu_func;
  logic         unused_ir;

  assign fpu_func  = ir[3:0];
  assign unused_ir = ^ir[26:4];

  control_decode #(.FPU_OPCODE(FPU_OPCODE)) u_decode (
    .opcode_i  (ir[31:27]),
    .cls_o     (cls),
    .alu_sel_o (dec_alu_sel)
  );

  // State register; clr abandons any partial instruction immediately
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_RESET_IDLE;
    else     state_q <= state_d;
  end

  // T-step sequencing; instruction length is chosen in T3 and T4
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET_IDLE: state_d = ST_T0;
      ST_T0:         state_d = ST_T1;
      ST_T1:         state_d = ST_T2;
      ST_T2:         state_d = ST_T3;
      ST_T3: begin
        if (cls == CLS_HALT)                                     state_d = ST_HALT;
        else if (cls == CLS_LD || cls == CLS_ST || cls == CLS_JAL) state_d = ST_T4;
        else                                                     state_d = ST_T0;
      end
      ST_T4:   state_d = (cls == CLS_LD) ? ST_T5 : ST_T0;
      ST_T5:   state_d = ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET_IDLE;
    endcase
  end

  // Per-step control decode; everything defaults low so idle/halt drive nothing
  always_comb begin
    ir_en = 1'b0;  pc_increment = 1'b0;  pc_in_alu = 1'b0;  pc_in_rf_a = 1'b0;
    ma_in_pc = 1'b0;  ma_in_alu = 1'b0;
    alu_a_in_rf = 1'b0;  alu_a_in_pc = 1'b0;  alu_b_in_rf = 1'b0;  alu_b_in_constant = 1'b0;
    lo_en = 1'b0;  hi_en = 1'b0;  memory_en = 1'b0;
    rf_in_alu = 1'b0;  rf_in_hi = 1'b0;  rf_in_lo = 1'b0;  rf_in_memory = 1'b0;  rf_in_fpu = 1'b0;
    alu_select = '0;  fpu_select = '0;  fpu_mode = 1'b0;
    run = (state_q != ST_RESET_IDLE) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin pc_increment = 1'b1; ma_in_pc = 1'b1; end
      ST_T2: ir_en = 1'b1;
      ST_T3: begin
        alu_select = dec_alu_sel;
        case (cls)
          CLS_ALU_R:  begin alu_a_in_rf = 1'b1; alu_b_in_rf = 1'b1; rf_in_alu = 1'b1; end
          CLS_ALU_I:  begin alu_a_in_rf = 1'b1; alu_b_in_constant = 1'b1; rf_in_alu = 1'b1; end
          CLS_ALU_U:  begin alu_a_in_rf = 1'b1; rf_in_alu = 1'b1; end
          CLS_MULDIV: begin alu_a_in_rf = 1'b1; alu_b_in_rf = 1'b1; lo_en = 1'b1; hi_en = 1'b1; end
          CLS_MFHI:   rf_in_hi = 1'b1;
          CLS_MFLO:   rf_in_lo = 1'b1;
          CLS_LD, CLS_ST:
                      begin alu_a_in_rf = 1'b1; alu_b_in_constant = 1'b1; ma_in_alu = 1'b1; end
          CLS_BR: begin
            alu_a_in_pc = 1'b1;
            alu_b_in_constant = 1'b1;
            pc_in_alu = BRANCH_TAKE ? branch_condition : 1'b0;
          end
          CLS_JR:     pc_in_rf_a = 1'b1;
          CLS_JAL:    begin alu_a_in_pc = 1'b1; alu_b_in_constant = 1'b1; rf_in_alu = 1'b1; end
          CLS_FPU: begin
            if (fpu_func < FPU_NFUNC) begin
              fpu_mode   = 1'b1;
              fpu_select = 12'd1 << fpu_func;
              rf_in_fpu  = fpu_writes_rf(fpu_func);
            end
          end
          default: ;
        endcase
      end
      ST_T4: begin
        if (cls == CLS_ST)  memory_en  = 1'b1;
        if (cls == CLS_JAL) pc_in_rf_a = 1'b1;
      end
      ST_T5: if (cls == CLS_LD) rf_in_memory = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: every T-step of each instruction is
// compared against hand-written expected control words at the falling edge.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        branch_condition;
  logic ir_en, pc_increment, pc_in_alu, pc_in_rf_a, ma_in_pc, ma_in_alu;
  logic alu_a_in_rf, alu_a_in_pc, alu_b_in_rf, alu_b_in_constant;
  logic lo_en, hi_en, memory_en;
  logic rf_in_alu, rf_in_hi, rf_in_lo, rf_in_memory, rf_in_fpu;
  logic [11:0] alu_select, fpu_select;
  logic fpu_mode, run;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [19:0] C_IR_EN  = 20'h80000, C_PC_INC = 20'h40000, C_PC_ALU = 20'h20000;
  localparam logic [19:0] C_PC_RFA = 20'h10000, C_MA_PC  = 20'h08000, C_MA_ALU = 20'h04000;
  localparam logic [19:0] C_A_RF   = 20'h02000, C_A_PC   = 20'h01000, C_B_RF   = 20'h00800;
  localparam logic [19:0] C_B_C    = 20'h00400, C_LO     = 20'h00200, C_HI     = 20'h00100;
  localparam logic [19:0] C_MEM    = 20'h00080, C_RF_ALU = 20'h00040, C_RF_HI  = 20'h00020;
  localparam logic [19:0] C_RF_LO  = 20'h00010, C_RF_MEM = 20'h00008, C_RF_FPU = 20'h00004;
  localparam logic [19:0] C_FPU    = 20'h00002, C_RUN    = 20'h00001;

  localparam logic [31:0] I_ADDI = {5'd11, 4'd1, 4'd0, 19'd355};
  localparam logic [31:0] I_SUB  = {5'd4,  4'd3, 4'd1, 4'd2, 15'd0};
  localparam logic [31:0] I_MUL  = {5'd14, 4'd0, 4'd1, 4'd2, 15'd0};
  localparam logic [31:0] I_NOT  = {5'd17, 4'd3, 4'd1, 19'd0};
  localparam logic [31:0] I_MFHI = {5'd23, 4'd5, 23'd0};
  localparam logic [31:0] I_LD   = {5'd0,  4'd1, 4'd2, 19'd4};
  localparam logic [31:0] I_ST   = {5'd2,  4'd1, 4'd2, 19'd8};
  localparam logic [31:0] I_BR   = {5'd18, 4'd1, 4'd0, 19'd12};
  localparam logic [31:0] I_JAL  = {5'd20, 4'd6, 23'd0};
  localparam logic [31:0] I_JR   = {5'd19, 4'd6, 23'd0};
  localparam logic [31:0] I_FADD = {5'd27, 23'd0, 4'd6};
  localparam logic [31:0] I_CFR  = {5'd27, 23'd0, 4'd3};
  localparam logic [31:0] I_NOP  = {5'd25, 27'd0};
  localparam logic [31:0] I_HALT = {5'd26, 27'd0};

  logic [19:0] ctrl;
  assign ctrl = {ir_en, pc_increment, pc_in_alu, pc_in_rf_a, ma_in_pc, ma_in_alu,
                 alu_a_in_rf, alu_a_in_pc, alu_b_in_rf, alu_b_in_constant,
                 lo_en, hi_en, memory_en, rf_in_alu, rf_in_hi, rf_in_lo,
                 rf_in_memory, rf_in_fpu, fpu_mode, run};

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .branch_condition(branch_condition),
    .ir_en(ir_en), .pc_increment(pc_increment), .pc_in_alu(pc_in_alu),
    .pc_in_rf_a(pc_in_rf_a), .ma_in_pc(ma_in_pc), .ma_in_alu(ma_in_alu),
    .alu_a_in_rf(alu_a_in_rf), .alu_a_in_pc(alu_a_in_pc), .alu_b_in_rf(alu_b_in_rf),
    .alu_b_in_constant(alu_b_in_constant), .lo_en(lo_en), .hi_en(hi_en),
    .memory_en(memory_en), .rf_in_alu(rf_in_alu), .rf_in_hi(rf_in_hi),
    .rf_in_lo(rf_in_lo), .rf_in_memory(rf_in_memory), .rf_in_fpu(rf_in_fpu),
    .alu_select(alu_select), .fpu_select(fpu_select), .fpu_mode(fpu_mode), .run(run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step(input string tag, input logic [19:0] ec,
                      input logic [11:0] ea, input logic [11:0] ef);
    @(negedge clk);
    chk({tag, ".ctrl"}, 32'(ctrl), 32'(ec));
    chk({tag, ".alu"},  32'(alu_select), 32'(ea));
    chk({tag, ".fpu"},  32'(fpu_select), 32'(ef));
  endtask

  task automatic fetch(input string tag, input logic [31:0] instr, input logic bc);
    @(posedge clk);
    #1;
    ir = instr;
    branch_condition = bc;
    step({tag, ".T0"}, C_PC_INC | C_MA_PC | C_RUN, 12'h000, 12'h000);
    step({tag, ".T1"}, C_RUN, 12'h000, 12'h000);
    step({tag, ".T2"}, C_IR_EN | C_RUN, 12'h000, 12'h000);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(posedge clk);
    step("clr_held", 20'h0, 12'h000, 12'h000);
    @(posedge clk);
    #1;
    clr = 1'b0;
    step("reset_idle", 20'h0, 12'h000, 12'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr = 1'b1;
    ir = 32'h0;
    branch_condition = 1'b0;
    do_reset();

    fetch("addi", I_ADDI, 1'b0);
    step("addi.T3", C_A_RF | C_B_C | C_RF_ALU | C_RUN, 12'h001, 12'h000);
    fetch("sub", I_SUB, 1'b0);
    step("sub.T3", C_A_RF | C_B_RF | C_RF_ALU | C_RUN, 12'h002, 12'h000);
    fetch("mul", I_MUL, 1'b0);
    step("mul.T3", C_A_RF | C_B_RF | C_LO | C_HI | C_RUN, 12'h100, 12'h000);
    fetch("not", I_NOT, 1'b0);
    step("not.T3", C_A_RF | C_RF_ALU | C_RUN, 12'h800, 12'h000);
    fetch("mfhi", I_MFHI, 1'b0);
    step("mfhi.T3", C_RF_HI | C_RUN, 12'h000, 12'h000);

    fetch("ld", I_LD, 1'b0);
    step("ld.T3", C_A_RF | C_B_C | C_MA_ALU | C_RUN, 12'h001, 12'h000);
    step("ld.T4", C_RUN, 12'h000, 12'h000);
    step("ld.T5", C_RF_MEM | C_RUN, 12'h000, 12'h000);
    fetch("st", I_ST, 1'b0);
    step("st.T3", C_A_RF | C_B_C | C_MA_ALU | C_RUN, 12'h001, 12'h000);
    step("st.T4", C_MEM | C_RUN, 12'h000, 12'h000);

    fetch("br0", I_BR, 1'b0);
    step("br0.T3", C_A_PC | C_B_C | C_RUN, 12'h001, 12'h000);
    fetch("br1", I_BR, 1'b1);
    step("br1.T3", C_A_PC | C_B_C | C_PC_ALU | C_RUN, 12'h001, 12'h000);

    fetch("jal", I_JAL, 1'b0);
    step("jal.T3", C_A_PC | C_B_C | C_RF_ALU | C_RUN, 12'h001, 12'h000);
    step("jal.T4", C_PC_RFA | C_RUN, 12'h000, 12'h000);
    fetch("jr", I_JR, 1'b0);
    step("jr.T3", C_PC_RFA | C_RUN, 12'h000, 12'h000);

    fetch("fadd", I_FADD, 1'b0);
    step("fadd.T3", C_FPU | C_RUN, 12'h000, 12'h040);
    fetch("cfr", I_CFR, 1'b0);
    step("cfr.T3", C_FPU | C_RF_FPU | C_RUN, 12'h000, 12'h008);
    fetch("nop", I_NOP, 1'b0);
    step("nop.T3", C_RUN, 12'h000, 12'h000);

    fetch("halt", I_HALT, 1'b0);
    step("halt.T3", C_RUN, 12'h000, 12'h000);
    for (int i = 0; i < 20; i++) step("halted", 20'h0, 12'h000, 12'h000);

    do_reset();
    fetch("ldclr", I_LD, 1'b0);
    step("ldclr.T3", C_A_RF | C_B_C | C_MA_ALU | C_RUN, 12'h001, 12'h000);
    step("ldclr.T4", C_RUN, 12'h000, 12'h000);
    clr = 1'b1;
    #1;
    chk("clr_mid_ld.ctrl", 32'(ctrl), 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    step("clr_mid_ld.idle", 20'h0, 12'h000, 12'h000);
    fetch("after_clr", I_ADDI, 1'b0);
    step("after_clr.T3", C_A_RF | C_B_C | C_RF_ALU | C_RUN, 12'h001, 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
